// File: rtl/i2c_master_ctrl.sv
// Single-byte I2C master: START, address+RW, one write or read byte, STOP.
// Open-drain SCL/SDA, quarter-period timing base of CLK_DIV cycles.
module i2c_master_ctrl #(
  parameter int CLK_DIV = 25
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic       START,
  input  logic       RW,
  input  logic [6:0] ADDR,
  input  logic [7:0] DATA_IN,
  output logic [7:0] DATA_OUT,
  output logic       BUSY,
  output logic       DONE,
  output logic       ACK_ERR,
  inout  wire        SCL,
  inout  wire        SDA
);

  localparam logic [15:0] QLAST = 16'(CLK_DIV - 1);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_ADDR,
    ST_WDATA,
    ST_RDATA,
    ST_STOP,
    ST_COMPLETE
  } state_t;

  state_t      state_reg;
  logic [15:0] qcnt_reg;
  logic [1:0]  quarter_reg;
  logic [3:0]  bit_reg;
  logic [6:0]  addr_reg;
  logic        rw_reg;
  logic [7:0]  data_reg;
  logic [7:0]  rx_reg;
  logic [7:0]  data_out_reg;
  logic        busy_reg;
  logic        done_reg;
  logic        ack_err_reg;
  logic        scl_low_reg;
  logic        sda_low_reg;
  logic        sda_meta_reg;
  logic        sda_sync_reg;

  logic        quarter_end;
  logic [7:0]  tx_byte;

  assign quarter_end = (qcnt_reg == QLAST);
  assign tx_byte     = (state_reg == ST_ADDR) ? {addr_reg, rw_reg} : data_reg;

  assign SCL      = scl_low_reg ? 1'b0 : 1'bz;
  assign SDA      = sda_low_reg ? 1'b0 : 1'bz;
  assign DATA_OUT = data_out_reg;
  assign BUSY     = busy_reg;
  assign DONE     = done_reg;
  assign ACK_ERR  = ack_err_reg;

  // Pull-down request for bit idx of a byte, MSB first; idx 8 is the ACK slot.
  function automatic logic tx_low(input logic [7:0] byte_v, input logic [3:0] idx);
    return (idx < 4'd8) ? ~byte_v[3'd7 - idx[2:0]] : 1'b0;
  endfunction

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      sda_meta_reg <= 1'b1;
      sda_sync_reg <= 1'b1;
    end else begin
      sda_meta_reg <= SDA;
      sda_sync_reg <= sda_meta_reg;
    end
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_reg    <= ST_IDLE;
      qcnt_reg     <= '0;
      quarter_reg  <= '0;
      bit_reg      <= '0;
      addr_reg     <= '0;
      rw_reg       <= 1'b0;
      data_reg     <= '0;
      rx_reg       <= '0;
      data_out_reg <= '0;
      busy_reg     <= 1'b0;
      done_reg     <= 1'b0;
      ack_err_reg  <= 1'b0;
      scl_low_reg  <= 1'b0;
      sda_low_reg  <= 1'b0;
    end else begin
      done_reg <= 1'b0;
      if (state_reg == ST_IDLE || state_reg == ST_COMPLETE) begin
        scl_low_reg <= 1'b0;
        sda_low_reg <= 1'b0;
        qcnt_reg    <= '0;
        quarter_reg <= '0;
        bit_reg     <= '0;
        if (START) begin
          addr_reg    <= ADDR;
          rw_reg      <= RW;
          data_reg    <= DATA_IN;
          ack_err_reg <= 1'b0;
          busy_reg    <= 1'b1;
          state_reg   <= ST_START;
        end else begin
          state_reg <= ST_IDLE;
        end
      end else if (!quarter_end) begin
        qcnt_reg <= qcnt_reg + 16'd1;
      end else begin
        qcnt_reg    <= '0;
        quarter_reg <= quarter_reg + 2'd1;
        case (state_reg)
          ST_START: begin
            if (quarter_reg == 2'd0) begin
              sda_low_reg <= 1'b1;
            end else begin
              state_reg   <= ST_ADDR;
              quarter_reg <= 2'd0;
              bit_reg     <= 4'd0;
              scl_low_reg <= 1'b1;
              sda_low_reg <= tx_low({addr_reg, rw_reg}, 4'd0);
            end
          end
          ST_ADDR, ST_WDATA, ST_RDATA: begin
            if (quarter_reg == 2'd1) begin
              scl_low_reg <= 1'b0;
            end else if (quarter_reg == 2'd3) begin
              // End of a bit: SCL falls and SDA takes the next bit value together.
              scl_low_reg <= 1'b1;
              if (bit_reg != 4'd8) begin
                bit_reg     <= bit_reg + 4'd1;
                sda_low_reg <= (state_reg == ST_RDATA) ? 1'b0 : tx_low(tx_byte, bit_reg + 4'd1);
                if (state_reg == ST_RDATA) begin
                  rx_reg <= {rx_reg[6:0], sda_sync_reg};
                end
              end else begin
                bit_reg <= 4'd0;
                if (state_reg == ST_ADDR && !sda_sync_reg) begin
                  state_reg   <= rw_reg ? ST_RDATA : ST_WDATA;
                  sda_low_reg <= rw_reg ? 1'b0 : tx_low(data_reg, 4'd0);
                end else begin
                  if (state_reg != ST_RDATA && sda_sync_reg) begin
                    ack_err_reg <= 1'b1;
                  end
                  state_reg   <= ST_STOP;
                  sda_low_reg <= 1'b1;
                end
              end
            end
          end
          ST_STOP: begin
            case (quarter_reg)
              2'd0:    scl_low_reg <= 1'b0;
              2'd1:    sda_low_reg <= 1'b0;
              default: begin
                state_reg <= ST_COMPLETE;
                busy_reg  <= 1'b0;
                done_reg  <= 1'b1;
                if (rw_reg && !ack_err_reg) begin
                  data_out_reg <= rx_reg;
                end
              end
            endcase
          end
          default: state_reg <= ST_IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_i2c_master_ctrl.sv
// Directed bench for i2c_master_ctrl with a behavioural I2C target at 7'h26.
module tb_i2c_master_ctrl;

  localparam int CLK_DIV = 4;
  localparam logic [6:0] SLV_ADDR = 7'h26;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic       rw = 1'b0;
  logic [6:0] addr = '0;
  logic [7:0] data_in = '0;
  logic [7:0] data_out;
  logic       busy;
  logic       done;
  logic       ack_err;
  wire        scl;
  wire        sda;

  pullup (scl);
  pullup (sda);

  logic slv_drv = 1'b0;
  assign sda = slv_drv ? 1'b0 : 1'bz;

  always #5 clk = ~clk;

  i2c_master_ctrl #(.CLK_DIV(CLK_DIV)) dut (
    .CLK      (clk),
    .RST      (rst_n),
    .START    (start),
    .RW       (rw),
    .ADDR     (addr),
    .DATA_IN  (data_in),
    .DATA_OUT (data_out),
    .BUSY     (busy),
    .DONE     (done),
    .ACK_ERR  (ack_err),
    .SCL      (scl),
    .SDA      (sda)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Monotonic bus/handshake counters; tests work on deltas.
  int busy_total = 0;
  int done_total = 0;
  always @(negedge clk) begin
    busy_total <= busy_total + (busy ? 1 : 0);
    done_total <= done_total + (done ? 1 : 0);
  end

  // Behavioural target: samples bus on the falling clock, ACKs its address.
  logic [7:0] rd_byte = 8'h00;
  logic       nack_data = 1'b0;
  logic       scl_q = 1'b1;
  logic       sda_q = 1'b1;
  int         bitn = 0;
  int         phase = 3;
  logic [7:0] shreg = '0;
  logic       sel = 1'b0;
  logic       rd = 1'b0;
  logic [7:0] addr_seen = '0;
  logic [7:0] data_seen = '0;
  logic       master_nack = 1'b0;
  int         starts = 0;
  int         stops = 0;
  int         rx_bytes = 0;

  always @(negedge clk) begin
    scl_q <= scl;
    sda_q <= sda;
    if (scl_q && scl && sda_q && !sda) begin
      starts  <= starts + 1;
      phase   <= 0;
      bitn    <= 0;
      slv_drv <= 1'b0;
    end else if (scl_q && scl && !sda_q && sda) begin
      stops   <= stops + 1;
      phase   <= 3;
      slv_drv <= 1'b0;
    end else if (!scl_q && scl) begin
      if (bitn < 8) shreg <= {shreg[6:0], sda};
      else if (phase == 2) master_nack <= sda;
      bitn <= bitn + 1;
    end else if (scl_q && !scl && phase != 3) begin
      if (bitn == 8) begin
        if (phase == 0) begin
          addr_seen <= shreg;
          rx_bytes  <= rx_bytes + 1;
          sel       <= (shreg[7:1] == SLV_ADDR);
          rd        <= shreg[0];
          slv_drv   <= (shreg[7:1] == SLV_ADDR);
        end else if (phase == 1) begin
          data_seen <= shreg;
          rx_bytes  <= rx_bytes + 1;
          slv_drv   <= !nack_data;
        end else begin
          slv_drv <= 1'b0;
        end
      end else if (bitn == 9) begin
        bitn <= 0;
        if (phase == 0 && sel) begin
          phase   <= rd ? 2 : 1;
          slv_drv <= rd && !rd_byte[7];
        end else begin
          phase   <= 3;
          slv_drv <= 1'b0;
        end
      end else if (phase == 2) begin
        slv_drv <= !rd_byte[7 - bitn];
      end
    end
  end

  int s_busy, s_done, s_start, s_stop, s_rx;

  task automatic snap();
    s_busy  = busy_total;
    s_done  = done_total;
    s_start = starts;
    s_stop  = stops;
    s_rx    = rx_bytes;
  endtask

  task automatic issue(input logic [6:0] a, input logic r, input logic [7:0] d);
    @(posedge clk); #1;
    start = 1'b1; addr = a; rw = r; data_in = d;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  // Returns on the falling edge where DONE is seen, or after the budget expires.
  task automatic wait_done(input string tag);
    logic ok;
    ok = 1'b0;
    for (int i = 0; i < 2000; i++) begin
      @(negedge clk);
      if (done) begin
        ok = 1'b1;
        break;
      end
    end
    #1;
    check({tag, "_done_seen"}, ok, 1'b1);
  endtask

  task automatic finish_txn(input string tag, input int exp_busy, input logic exp_err, input int exp_rx);
    wait_done(tag);
    check({tag, "_busy_cycles"}, busy_total - s_busy, exp_busy);
    check({tag, "_ack_err"}, ack_err, exp_err);
    check({tag, "_starts"}, starts - s_start, 1);
    check({tag, "_stops"}, stops - s_stop, 1);
    check({tag, "_rx_bytes"}, rx_bytes - s_rx, exp_rx);
    @(negedge clk); #1;
    check({tag, "_done_pulse"}, {done, 8'(done_total - s_done)}, {1'b0, 8'd1});
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) @(negedge clk);
    check("rst_busy", busy, 1'b0);
    check("rst_done", done, 1'b0);
    check("rst_ack_err", ack_err, 1'b0);
    check("rst_data_out", data_out, 8'h00);
    check("rst_scl", scl, 1'b1);
    check("rst_sda", sda, 1'b1);
    @(posedge clk); #1;
    rst_n = 1'b1;
    repeat (3) @(posedge clk);

    // Write, ACKed: address byte 0x26<<1|0 = 0x4C, data 0x4C.
    snap();
    issue(7'h26, 1'b0, 8'h4C);
    finish_txn("wr", 77 * CLK_DIV, 1'b0, 2);
    check("wr_addr_byte", addr_seen, 8'h4C);
    check("wr_data_byte", data_seen, 8'h4C);
    check("wr_data_out_held", data_out, 8'h00);

    // Read, target returns 0x4C; master must NACK the byte.
    rd_byte = 8'h4C;
    snap();
    issue(7'h26, 1'b1, 8'h00);
    finish_txn("rd", 77 * CLK_DIV, 1'b0, 1);
    check("rd_addr_byte", addr_seen, 8'h4D);
    check("rd_data_out", data_out, 8'h4C);
    check("rd_master_nack", master_nack, 1'b1);

    rd_byte = 8'hA5;
    snap();
    issue(7'h26, 1'b1, 8'h00);
    finish_txn("rd2", 77 * CLK_DIV, 1'b0, 1);
    check("rd2_data_out", data_out, 8'hA5);

    // Address NACK on a read: short transaction, DATA_OUT untouched.
    snap();
    issue(7'h27, 1'b1, 8'h00);
    finish_txn("anack", 41 * CLK_DIV, 1'b1, 1);
    check("anack_addr_byte", addr_seen, 8'h4F);
    check("anack_data_out", data_out, 8'hA5);

    // Write-data NACK.
    nack_data = 1'b1;
    snap();
    issue(7'h26, 1'b0, 8'hB3);
    finish_txn("dnack", 77 * CLK_DIV, 1'b1, 2);
    check("dnack_data_byte", data_seen, 8'hB3);
    nack_data = 1'b0;

    // START while busy is ignored; START during the DONE cycle is accepted.
    snap();
    issue(7'h26, 1'b0, 8'h5A);
    repeat (100) @(posedge clk);
    #1;
    start = 1'b1; addr = 7'h27; rw = 1'b1; data_in = 8'hFF;
    @(posedge clk); #1;
    start = 1'b0;
    rd_byte = 8'h3C;
    wait_done("ign");
    start = 1'b1; addr = 7'h26; rw = 1'b1; data_in = 8'h00;
    check("ign_busy_cycles", busy_total - s_busy, 77 * CLK_DIV);
    check("ign_ack_err", ack_err, 1'b0);
    check("ign_addr_byte", addr_seen, 8'h4C);
    check("ign_data_byte", data_seen, 8'h5A);
    check("ign_rx_bytes", rx_bytes - s_rx, 2);
    check("ign_starts", starts - s_start, 1);
    snap();
    @(posedge clk); #1;
    start = 1'b0;
    check("b2b_busy_next", busy, 1'b1);
    finish_txn("b2b", 77 * CLK_DIV, 1'b0, 1);
    check("b2b_addr_byte", addr_seen, 8'h4D);
    check("b2b_data_out", data_out, 8'h3C);

    // Asynchronous reset during the read data bits.
    rd_byte = 8'hFF;
    snap();
    issue(7'h26, 1'b1, 8'h00);
    repeat (170) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("arst_scl", scl, 1'b1);
    check("arst_sda", sda, 1'b1);
    check("arst_busy", busy, 1'b0);
    check("arst_done", done, 1'b0);
    check("arst_data_out", data_out, 8'h00);
    repeat (3) @(negedge clk);
    check("arst_hold_busy", busy, 1'b0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    repeat (2) @(posedge clk);
    snap();
    issue(7'h26, 1'b0, 8'h3C);
    finish_txn("post_rst", 77 * CLK_DIV, 1'b0, 2);
    check("post_rst_data_byte", data_seen, 8'h3C);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/i2c_master_ctrl.md
Name: i2c_master_ctrl

Overview:
Synthesizable single-byte I2C master (initiator) for the FPGA_I2C design. It accepts one command at a time: a 7-bit target address, a direction and a byte to write. It then generates START, the address phase, one data byte, the ACK phases and STOP on open-drain SCL/SDA. It reports a read byte, an ACK error and completion to the host logic.

Parameters:
CLK_DIV, 25, CLK cycles per SCL quarter-period; legal range 4..65535; SCL period = 4*CLK_DIV cycles.

Ports:
CLK  input  1  system clock; all logic on rising edge.
RST  input  1  asynchronous, active-low reset.
START  input  1  command strobe; sampled only while BUSY=0.
RW  input  1  0 = write DATA_IN to target, 1 = read one byte from target.
ADDR  input  7  target address.
DATA_IN  input  8  byte to write.
DATA_OUT  output  8  last byte read.
BUSY  output  1  transaction in progress.
DONE  output  1  one-cycle completion pulse.
ACK_ERR  output  1  target NACKed the address or the write-data byte.
SCL  inout  1  open drain: drives 0 or releases (z); no clock stretching.
SDA  inout  1  open drain: drives 0 or releases (z).

Behaviour:
- Reset (RST=0, asynchronous): state IDLE; SCL and SDA released (z); BUSY=0, DONE=0, ACK_ERR=0, DATA_OUT=8'h00; counters cleared. Asserting reset mid-transaction releases both lines immediately; no STOP is generated.
- SDA input passes through a 2-flop synchronizer (reset value 1).
- Accept: on a rising edge with START=1 and BUSY=0:
  - Latch ADDR, RW and DATA_IN.
  - Clear ACK_ERR.
  - BUSY=1 from the next cycle.
- START while BUSY=1 is ignored; latched values are unaffected.
- Timing base: a quarter counter runs 0..CLK_DIV-1. Each bit takes 4 quarters:
  - Q0: SCL low; SDA updated at the start of Q0.
  - Q1: SCL low.
  - Q2 and Q3: SCL released.
  - Read sample: the synchronized SDA is sampled on the last cycle of Q3.
- States and their quarter counts:
  - IDLE: lines released.
  - START (2 quarters): SCL and SDA released, then SDA low with SCL released.
  - ADDR (9 bits): {ADDR,RW}, MSB first, then the ACK bit with SDA released. Sampled 0 = ACK.
  - Branch after ADDR: on NACK, set ACK_ERR=1 and go to STOP. Otherwise go to WDATA if RW=0, or RDATA if RW=1.
  - WDATA (9 bits): DATA_IN, MSB first, then the ACK bit. A sampled 1 sets ACK_ERR=1.
  - RDATA (9 bits): SDA released for 8 bits; samples are shifted in MSB first. On the 9th bit the master sends NACK (SDA released) as the single-byte terminator.
  - STOP (3 quarters): SCL low with SDA low, then SCL released with SDA low, then both released.
  - COMPLETE: the cycle after the last STOP quarter. DONE=1 and BUSY=0 in that same cycle; return to IDLE. A START in that cycle is accepted.
- Total lengths, counted as BUSY=1 cycles:
  - Full transaction (write or read): 77*CLK_DIV.
  - Address NACK: 41*CLK_DIV.
- DATA_OUT is updated only at COMPLETE of a read with address ACKed; otherwise it holds.
- ACK_ERR holds its value until the next accept.
- SDA never changes while SCL is released, except the START and STOP edges.

Test Plan:
- Write ACKed: bench slave at 7'h26 ACKs everything; CLK_DIV=4; START with ADDR=7'h26, RW=0, DATA_IN=8'h4C.
  -> Slave receives 0x4C then 0x4C; BUSY high exactly 308 cycles; DONE 1 pulse; ACK_ERR=0.
- Read: slave returns 8'h4C; RW=1.
  -> DATA_OUT=8'h4C at DONE; master leaves SDA released on the 9th bit (NACK); STOP is seen; ACK_ERR=0.
- Address NACK: ADDR=7'h27 with slave at 7'h26.
  -> No data phase; STOP directly after the address ACK bit; BUSY 164 cycles; ACK_ERR=1; DATA_OUT unchanged.
- Write-data NACK: slave ACKs the address and NACKs the data.
  -> ACK_ERR=1 at DONE; full 308-cycle length; STOP is generated.
- START while busy: pulse START with different ADDR/DATA_IN mid-transaction.
  -> Ignored; bus traffic matches the first command; a START coincident with the DONE cycle begins a new transaction on the next cycle.
- Reset mid-read: drop RST during the RDATA bits.
  -> SCL=z, SDA=z, BUSY=0, DONE=0, DATA_OUT=8'h00 immediately; after release, a new command completes normally.
